hex_loader: RTL and testbench

Parametrised serial program loader for HERA command memory. Receives ASCII hex text from a terminal over the null-modem port (8N1, no parity), assembles `DATA_W`-bit words, and writes them to sequential RAM addresses. Supports an `@` address-set command and an end-of-transmission word, which triggers a timed reset pulse to HERA. Sits between the serial port pins and the command-memory write port, in place of the fixed 16-bit loader.

---
 rtl/hex_loader.sv | 200 ++++++++++++++++++++
 tb/tb_hex_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_loader.sv
// hex_loader: serial hex-text loader for HERA command memory; HEX_LOADER_ECHO_EN adds an 8N1 echo transmitter on tx.
module hex_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int OVS_DIV = 1250,
    parameter logic [DATA_W-1:0] END_WORD = '0,
    parameter int RES_CYCLES = 4096
) (
    input  logic              clk_48,
    input  logic              rst,
    input  logic              rd,
    input  logic              dtr,
    input  logic              rts,
    output logic              dsr,
    output logic              cd,
    output logic              cts,
    output logic              tx,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              wren,
    output logic              resout,
    output logic              frame_err
);
    localparam int OVS_W = $clog2(OVS_DIV + 1);
    localparam int ND = DATA_W / 4;
    localparam int NA = (ADDR_W + 3) / 4;
    localparam int AW4 = NA * 4;
    localparam int RES_W = $clog2(RES_CYCLES + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
    typedef enum logic [1:0] {P_WORD, P_ADDR, P_DONE} ps_t;

    rx_t rx_state, rx_next;
    ps_t ps, ps_next;
    logic rd_s1, rd_s2, rd_s3, fall, tick, at_mid, at_end, byte_valid, is_hex;
    logic [OVS_W-1:0] ovs_cnt;
    logic [3:0] tick_cnt, dcnt, nib;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [DATA_W-1:0] wasm, wnext;
    logic [AW4-1:0] aasm, anext;
    logic [RES_W-1:0] res_cnt;

    assign dsr = dtr;
    assign cd = dtr;
    assign cts = rts;
    assign fall = rd_s3 & ~rd_s2;
    assign tick = ovs_cnt == OVS_W'(OVS_DIV - 1);

    always_ff @(posedge clk_48) begin
        if (rst) {rd_s1, rd_s2, rd_s3} <= 3'b111;
        else {rd_s1, rd_s2, rd_s3} <= {rd, rd_s1, rd_s2};
    end

    always_ff @(posedge clk_48) begin
        rx_state <= rst ? R_IDLE : rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (fall) rx_next = R_START;
            R_START: if (at_mid) rx_next = rd_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (at_end && bit_cnt == 3'd7) rx_next = R_STOP;
            R_STOP:  if (at_end) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        at_mid = tick && tick_cnt == 4'd7;
        at_end = tick && tick_cnt == 4'd15;
    end

    // tick phase restarts on the start edge so samples land mid-bit
    always_ff @(posedge clk_48) begin
        if (rst) begin
            ovs_cnt <= '0;
            tick_cnt <= '0;
            bit_cnt <= '0;
            rx_shift <= '0;
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovs_cnt <= ((rx_state == R_IDLE && fall) || tick) ? '0 : ovs_cnt + 1'b1;
            tick_cnt <= (rx_next != rx_state) ? '0 : tick ? tick_cnt + 4'd1 : tick_cnt;
            if (rx_state == R_DATA && at_end) begin
                rx_shift <= {rd_s2, rx_shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            byte_valid <= rx_state == R_STOP && at_end && rd_s2;
            frame_err <= rx_state == R_STOP && at_end && !rd_s2;
        end
    end

    always_comb begin
        is_hex = (rx_shift >= 8'h30 && rx_shift <= 8'h39) || (rx_shift >= 8'h41 && rx_shift <= 8'h46) ||
                 (rx_shift >= 8'h61 && rx_shift <= 8'h66);
        nib = rx_shift <= 8'h39 ? rx_shift[3:0] : rx_shift[3:0] + 4'd9;
        wnext = (wasm << 4) | DATA_W'(nib);
        anext = (aasm << 4) | AW4'(nib);
    end

    always_ff @(posedge clk_48) begin
        ps <= rst ? P_WORD : ps_next;
    end

    always_comb begin
        ps_next = ps;
        case (ps)
            P_WORD:  if (wren && data == END_WORD) ps_next = P_DONE;
                     else if (byte_valid && rx_shift == 8'h40) ps_next = P_ADDR;
            P_ADDR:  if (byte_valid && (!is_hex || dcnt == 4'(NA - 1))) ps_next = P_WORD;
            default: ps_next = ps;
        endcase
    end

    always_comb begin
        resout = !(ps == P_DONE && res_cnt != RES_W'(RES_CYCLES));
    end

    always_ff @(posedge clk_48) begin
        if (rst) begin
            data <= '0;
            addr <= '0;
            wren <= 1'b0;
            dcnt <= '0;
            wasm <= '0;
            aasm <= '0;
            res_cnt <= '0;
        end else begin
            wren <= 1'b0;
            if (wren) addr <= addr + 1'b1;
            if (ps == P_DONE && res_cnt != RES_W'(RES_CYCLES)) res_cnt <= res_cnt + 1'b1;
            if (byte_valid && ps != P_DONE) begin
                if (ps == P_WORD && is_hex) begin
                    wasm <= wnext;
                    dcnt <= dcnt == 4'(ND - 1) ? '0 : dcnt + 4'd1;
                    if (dcnt == 4'(ND - 1)) begin
                        data <= wnext;
                        wren <= 1'b1;
                    end
                end else if (ps == P_ADDR && is_hex) begin
                    aasm <= anext;
                    dcnt <= dcnt == 4'(NA - 1) ? '0 : dcnt + 4'd1;
                    if (dcnt == 4'(NA - 1)) addr <= anext[ADDR_W-1:0];
                end else begin
                    dcnt <= '0;
                end
            end
        end
    end

`ifdef HEX_LOADER_ECHO_EN
    localparam int BIT_CYC = 16 * OVS_DIV;
    localparam int BW = $clog2(BIT_CYC + 1);
    logic [7:0] hold;
    logic hold_full, tx_busy, tx_load;
    logic [9:0] tx_shift;
    logic [3:0] tx_bits;
    logic [BW-1:0] tx_div;

    assign tx_load = !tx_busy && hold_full;
    assign tx = tx_busy ? tx_shift[0] : 1'b1;

    // a byte arriving with the holding register still full is not echoed
    always_ff @(posedge clk_48) begin
        if (rst) begin
            hold <= '0;
            hold_full <= 1'b0;
            tx_busy <= 1'b0;
            tx_shift <= '1;
            tx_bits <= '0;
            tx_div <= '0;
        end else begin
            if (byte_valid && (!hold_full || tx_load)) begin
                hold <= rx_shift;
                hold_full <= 1'b1;
            end else if (tx_load) begin
                hold_full <= 1'b0;
            end
            if (tx_load) begin
                tx_shift <= {1'b1, hold, 1'b0};
                tx_busy <= 1'b1;
                tx_bits <= '0;
                tx_div <= '0;
            end else if (tx_busy) begin
                tx_div <= tx_div == BW'(BIT_CYC - 1) ? '0 : tx_div + 1'b1;
                if (tx_div == BW'(BIT_CYC - 1)) begin
                    tx_shift <= {1'b1, tx_shift[9:1]};
                    tx_bits <= tx_bits + 4'd1;
                    tx_busy <= tx_bits != 4'd9;
                end
            end
        end
    end
`else
    assign tx = 1'b1;
`endif
endmodule

// File: tb/tb_hex_loader.sv
// tb_hex_loader: directed bench for hex_loader, 16-bit and 8-bit instances with a fast bit clock.
module tb_hex_loader;
    localparam int OVS = 2;
    localparam int BIT = 16 * OVS;

    logic clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    logic rst0, rst1, rd0, rd1, dtr, rts;
    logic dsr0, cd0, cts0, tx0, wren0, resout0, fe0;
    logic dsr1, cd1, cts1, tx1, wren1, resout1, fe1;
    logic [15:0] data0;
    logic [9:0] addr0;
    logic [7:0] data1;
    logic [3:0] addr1;

    hex_loader #(.DATA_W(16), .ADDR_W(10), .OVS_DIV(OVS), .END_WORD(16'h0000), .RES_CYCLES(4096)) dut0 (
        .clk_48(clk_48), .rst(rst0), .rd(rd0), .dtr(dtr), .rts(rts), .dsr(dsr0), .cd(cd0), .cts(cts0),
        .tx(tx0), .data(data0), .addr(addr0), .wren(wren0), .resout(resout0), .frame_err(fe0));

    hex_loader #(.DATA_W(8), .ADDR_W(4), .OVS_DIV(OVS), .END_WORD(8'h00), .RES_CYCLES(4096)) dut1 (
        .clk_48(clk_48), .rst(rst1), .rd(rd1), .dtr(dtr), .rts(rts), .dsr(dsr1), .cd(cd1), .cts(cts1),
        .tx(tx1), .data(data1), .addr(addr1), .wren(wren1), .resout(resout1), .frame_err(fe1));

    int checks = 0, failures = 0, cyc = 0;
    int low_cnt = 0, low_start = -1, end_wren_cyc = -1, fe_cnt = 0, tx_low = 0;
    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

    always @(posedge clk_48) cyc <= cyc + 1;

    always @(negedge clk_48) begin
        if (wren0) begin
            wa0.push_back(32'(addr0));
            wd0.push_back(32'(data0));
            if (data0 == 16'h0000) end_wren_cyc = cyc;
        end
        if (wren1) begin
            wa1.push_back(32'(addr1));
            wd1.push_back(32'(data1));
        end
        if (!resout0) begin
            if (low_cnt == 0) low_start = cyc;
            low_cnt++;
        end
        if (fe0) fe_cnt++;
        if (!tx0) tx_low++;
    end

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return i < q.size() ? q[i] : 'x;
    endfunction

    task automatic send(input int which, input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (which == 0) rd0 = f[i]; else rd1 = f[i];
            repeat (BIT) @(posedge clk_48);
            #1;
        end
        if (which == 0) rd0 = 1'b1; else rd1 = 1'b1;
        repeat (2 * BIT) @(posedge clk_48);
        #1;
    endtask

    task automatic send_str(input int which, input string s);
        for (int i = 0; i < s.len(); i++) send(which, s[i]);
    endtask

    task automatic do_reset();
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (3) @(posedge clk_48);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        low_cnt = 0; low_start = -1; end_wren_cyc = -1; fe_cnt = 0; tx_low = 0;
    endtask

    task automatic test_reset();
        rd0 = 1'b1; rd1 = 1'b1; dtr = 1'b1; rts = 1'b1;
        do_reset();
        #1;
        checks++; if (data0 !== 16'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", data0); end
        checks++; if (addr0 !== 10'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr0); end
        checks++; if (wren0 !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", wren0); end
        checks++; if (resout0 !== 1'b1) begin failures++; $display("FAIL rst_resout got=%b exp=1", resout0); end
        checks++; if (fe0 !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b exp=0", fe0); end
        checks++; if (tx0 !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", tx0); end
        checks++; if ({dsr0, cd0, cts0} !== 3'b111) begin failures++; $display("FAIL modem_hi got=%b exp=111", {dsr0, cd0, cts0}); end
        dtr = 1'b0; #1;
        checks++; if ({dsr0, cd0, cts0} !== 3'b001) begin failures++; $display("FAIL modem_dtr got=%b exp=001", {dsr0, cd0, cts0}); end
        rts = 1'b0; dtr = 1'b1; #1;
        checks++; if ({dsr0, cd0, cts0} !== 3'b110) begin failures++; $display("FAIL modem_rts got=%b exp=110", {dsr0, cd0, cts0}); end
    endtask

    task automatic test_load_end();
        do_reset();
        send_str(0, "12AB0000");
        checks++; if (wa0.size() != 2) begin failures++; $display("FAIL load_count got=%0d exp=2", wa0.size()); end
        checks++; if (at(wa0, 0) !== 32'h0 || at(wd0, 0) !== 32'h12AB) begin failures++; $display("FAIL load_w0 got=%h@%h exp=12ab@0", at(wd0, 0), at(wa0, 0)); end
        checks++; if (at(wa0, 1) !== 32'h1 || at(wd0, 1) !== 32'h0) begin failures++; $display("FAIL load_w1 got=%h@%h exp=0@1", at(wd0, 1), at(wa0, 1)); end
        repeat (4200) @(posedge clk_48);
        #1;
        checks++; if (low_cnt != 4096) begin failures++; $display("FAIL resout_len got=%0d exp=4096", low_cnt); end
        checks++; if (low_start != end_wren_cyc + 1) begin failures++; $display("FAIL resout_start got=%0d exp=%0d", low_start, end_wren_cyc + 1); end
        checks++; if (resout0 !== 1'b1) begin failures++; $display("FAIL resout_after got=%b exp=1", resout0); end
        send_str(0, "FFFF");
        checks++; if (wa0.size() != 2) begin failures++; $display("FAIL done_ignore got=%0d exp=2", wa0.size()); end
    endtask

    task automatic test_discard();
        do_reset();
        send_str(0, "12x34AB");
        checks++; if (wa0.size() != 1) begin failures++; $display("FAIL discard_count got=%0d exp=1", wa0.size()); end
        checks++; if (at(wa0, 0) !== 32'h0 || at(wd0, 0) !== 32'h34AB) begin failures++; $display("FAIL discard_w got=%h@%h exp=34ab@0", at(wd0, 0), at(wa0, 0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        send_str(0, "@3FE111122223333");
        checks++; if (wa0.size() != 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", wa0.size()); end
        checks++; if (at(wa0, 0) !== 32'h3FE || at(wd0, 0) !== 32'h1111) begin failures++; $display("FAIL wrap_w0 got=%h@%h exp=1111@3fe", at(wd0, 0), at(wa0, 0)); end
        checks++; if (at(wa0, 1) !== 32'h3FF || at(wd0, 1) !== 32'h2222) begin failures++; $display("FAIL wrap_w1 got=%h@%h exp=2222@3ff", at(wd0, 1), at(wa0, 1)); end
        checks++; if (at(wa0, 2) !== 32'h000 || at(wd0, 2) !== 32'h3333) begin failures++; $display("FAIL wrap_w2 got=%h@%h exp=3333@0", at(wd0, 2), at(wa0, 2)); end
        checks++; if (addr0 !== 10'h001) begin failures++; $display("FAIL wrap_addr got=%h exp=001", addr0); end
    endtask

    task automatic test_addr_abort();
        do_reset();
        send_str(0, "@1zABCD");
        checks++; if (wa0.size() != 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", wa0.size()); end
        checks++; if (at(wa0, 0) !== 32'h0 || at(wd0, 0) !== 32'hABCD) begin failures++; $display("FAIL abort_w got=%h@%h exp=abcd@0", at(wd0, 0), at(wa0, 0)); end
    endtask

    task automatic test_frame_err();
        do_reset();
        send(0, "1", 1'b0);
        checks++; if (fe_cnt != 1) begin failures++; $display("FAIL frame_pulse got=%0d exp=1", fe_cnt); end
        send_str(0, "2345");
        checks++; if (wa0.size() != 1) begin failures++; $display("FAIL frame_count got=%0d exp=1", wa0.size()); end
        checks++; if (at(wd0, 0) !== 32'h2345) begin failures++; $display("FAIL frame_w got=%h exp=2345", at(wd0, 0)); end
    endtask

    task automatic test_small();
        do_reset();
        send_str(1, "5AC3");
        checks++; if (at(wa1, 0) !== 32'h0 || at(wd1, 0) !== 32'h5A) begin failures++; $display("FAIL small_w0 got=%h@%h exp=5a@0", at(wd1, 0), at(wa1, 0)); end
        checks++; if (at(wa1, 1) !== 32'h1 || at(wd1, 1) !== 32'hC3) begin failures++; $display("FAIL small_w1 got=%h@%h exp=c3@1", at(wd1, 1), at(wa1, 1)); end
        checks++; if (addr1 !== 4'h2) begin failures++; $display("FAIL small_addr got=%h exp=2", addr1); end
        send(1, "7");
        rst1 = 1'b1;
        repeat (2) @(posedge clk_48);
        #1;
        rst1 = 1'b0;
        checks++; if (addr1 !== 4'h0 || data1 !== 8'h0) begin failures++; $display("FAIL small_rst got=%h@%h exp=00@0", data1, addr1); end
        send_str(1, "E1");
        checks++; if (wa1.size() != 3) begin failures++; $display("FAIL small_count got=%0d exp=3", wa1.size()); end
        checks++; if (at(wa1, 2) !== 32'h0 || at(wd1, 2) !== 32'hE1) begin failures++; $display("FAIL small_after_rst got=%h@%h exp=e1@0", at(wd1, 2), at(wa1, 2)); end
    endtask

    task automatic test_echo();
        do_reset();
`ifdef HEX_LOADER_ECHO_EN
        begin
            logic [9:0] seen;
            int n;
            seen = '1;
            n = 0;
            fork
                send(0, "A");
                begin
                    while (tx0 !== 1'b0 && n < 3000) begin
                        @(posedge clk_48);
                        #1;
                        n++;
                    end
                    if (n < 3000) begin
                        repeat (BIT / 2) @(posedge clk_48);
                        #1;
                        for (int i = 0; i < 10; i++) begin
                            seen[i] = tx0;
                            repeat (BIT) @(posedge clk_48);
                            #1;
                        end
                    end
                end
            join
            checks++; if (n >= 3000) begin failures++; $display("FAIL echo_start got=timeout exp=start bit"); end
            checks++; if (seen !== {1'b1, 8'h41, 1'b0}) begin failures++; $display("FAIL echo_frame got=%b exp=%b", seen, {1'b1, 8'h41, 1'b0}); end
        end
`else
        send(0, "A");
        checks++; if (tx_low != 0) begin failures++; $display("FAIL echo_off got=%0d low cycles exp=0", tx_low); end
`endif
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rd0 = 1'b1; rd1 = 1'b1; dtr = 1'b0; rts = 1'b0;
        test_reset();
        test_load_end();
        test_discard();
        test_wrap();
        test_addr_abort();
        test_frame_err();
        test_small();
        test_echo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
